// File: rtl/serial_bus_master_tx.sv
// Master-side serializer for the decoder bus: address phase, turnaround gap, data phase, release gap.
// Build option SER_TX_ADDR_CHECK_EN pre-decodes the address and rejects unmapped targets with err.
module serial_bus_master_tx #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              tx_en,
    output logic              bus_data_out,
    output logic              bus_data_out_valid,
    output logic              bus_mode,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // state | meaning
    // IDLE  | no transaction; the next emission is nothing
    // ADDR  | next enabled edge emits the next address bit (mode 0)
    // GAP_A | next enabled edge emits a turnaround gap cycle (mode 1, valid 0)
    // DATA  | next enabled edge emits the next data bit (mode 1)
    // GAP_D | next enabled edge emits a release gap cycle (mode 0); first one carries done

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int BIT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        GAP_A = 3'd2,
        DATA  = 3'd3,
        GAP_D = 3'd4
    } state_t;

    state_t            state, state_d, cur;
    logic [ADDR_W-1:0] addr_sr, addr_sr_d, a_src;
    logic [DATA_W-1:0] data_sr, data_sr_d, d_src;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [3:0]        gap_cnt, gap_cnt_d;
    logic              out_d, valid_d, mode_d, done_d, ready_d, busy_d;
    logic              accept, reject, addr_hit;

`ifdef SER_TX_ADDR_CHECK_EN
    always_comb begin
        addr_hit = (req_addr[15:11] == 5'b00000) ||
                   (req_addr[15:14] == 2'b01)    ||
                   (req_addr[15:12] == 4'b1000);
    end
`else
    assign addr_hit = 1'b1;
`endif

    // The accept edge already performs the first emission, so the
    // shift sources come straight from the request ports on that edge.
    always_comb begin
        accept    = (state == IDLE) && req_valid && req_ready;
        reject    = accept && !addr_hit;
        cur       = (accept && addr_hit) ? ADDR : state;
        a_src     = accept ? req_addr : addr_sr;
        d_src     = accept ? req_data : data_sr;

        state_d   = cur;
        addr_sr_d = a_src;
        data_sr_d = d_src;
        bit_cnt_d = accept ? '0 : bit_cnt;
        gap_cnt_d = accept ? '0 : gap_cnt;
        out_d     = bus_data_out;
        valid_d   = 1'b0;
        mode_d    = bus_mode;
        done_d    = reject;

        if (cur == IDLE) begin
            out_d  = 1'b0;
            mode_d = 1'b0;
        end else if (tx_en) begin
            case (cur)
                ADDR: begin
                    out_d     = a_src[0];
                    valid_d   = 1'b1;
                    mode_d    = 1'b0;
                    addr_sr_d = a_src >> 1;
                    if (bit_cnt_d == BIT_W'(ADDR_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = GAP_A;
                    end else begin
                        bit_cnt_d = bit_cnt_d + BIT_W'(1);
                    end
                end
                GAP_A: begin
                    out_d  = 1'b0;
                    mode_d = 1'b1;
                    if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
                        gap_cnt_d = '0;
                        state_d   = DATA;
                    end else begin
                        gap_cnt_d = gap_cnt + 4'd1;
                    end
                end
                DATA: begin
                    out_d     = d_src[0];
                    valid_d   = 1'b1;
                    mode_d    = 1'b1;
                    data_sr_d = d_src >> 1;
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = GAP_D;
                    end else begin
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                    end
                end
                GAP_D: begin
                    out_d  = 1'b0;
                    mode_d = 1'b0;
                    done_d = (gap_cnt == 4'd0);
                    if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
                        gap_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Ready follows the registered state, so it rises one cycle after the last gap.
        ready_d = (state == IDLE) && !accept;
        busy_d  = (state != IDLE) || (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            addr_sr            <= '0;
            data_sr            <= '0;
            bit_cnt            <= '0;
            gap_cnt            <= '0;
            bus_data_out       <= 1'b0;
            bus_data_out_valid <= 1'b0;
            bus_mode           <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            req_ready          <= 1'b0;
        end else begin
            state              <= state_d;
            addr_sr            <= addr_sr_d;
            data_sr            <= data_sr_d;
            bit_cnt            <= bit_cnt_d;
            gap_cnt            <= gap_cnt_d;
            bus_data_out       <= out_d;
            bus_data_out_valid <= valid_d;
            bus_mode           <= mode_d;
            busy               <= busy_d;
            done               <= done_d;
            req_ready          <= ready_d;
        end
    end

`ifdef SER_TX_ADDR_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= reject;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_bus_master_tx.sv
// Scoreboard bench for serial_bus_master_tx: expected bus bits are queued at accept and
// popped by a bus monitor; per-transaction timing is checked against the cycle budget.
module tb_serial_bus_master_tx;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int GAP    = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_data;
    logic        tx_en;
    logic        bus_data_out;
    logic        bus_data_out_valid;
    logic        bus_mode;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];

    serial_bus_master_tx #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_data(req_data),
        .tx_en(tx_en),
        .bus_data_out(bus_data_out),
        .bus_data_out_valid(bus_data_out_valid),
        .bus_mode(bus_mode),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

`ifdef SER_TX_ADDR_CHECK_EN
    function automatic bit map_hit(input logic [15:0] a);
        return (a[15:11] == 5'b00000) || (a[15:14] == 2'b01) || (a[15:12] == 4'b1000);
    endfunction
`endif

    task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
        for (int i = 0; i < ADDR_W; i++) exp_q.push_back({1'b0, a[i]});
        for (int i = 0; i < DATA_W; i++) exp_q.push_back({1'b1, d[i]});
    endtask

    // bus monitor: every qualified bit must be the next queued one
    always @(negedge clk) begin
        if (rst_n && bus_data_out_valid) begin
            if (exp_q.size() == 0) begin
                chk("extra_bit", {30'd0, bus_mode, bus_data_out}, 32'hFFFF_FFFF);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                chk("bus_bit", {30'd0, bus_mode, bus_data_out}, {30'd0, e});
            end
        end
    end

    // Called at a negedge. Stall windows are cycles (relative to accept) with tx_en low.
    task automatic send(input string tag, input logic [15:0] a, input logic [7:0] d,
                        input bit keep, input logic [15:0] na, input logic [7:0] nd,
                        input int st1, input int ln1, input int st2, input int ln2,
                        input int gapa_k, input int abort_k);
        bit         mapped;
        bit         stalled_prev;
        logic [1:0] prev_mb;
        int         done_lat, rdy_lat, ndone, n, exp_done, exp_rdy;
`ifdef SER_TX_ADDR_CHECK_EN
        mapped = map_hit(a);
`else
        mapped = 1'b1;
`endif
        exp_done = mapped ? (ADDR_W + DATA_W + GAP + 1 + ln1 + ln2) : 1;
        exp_rdy  = mapped ? (ADDR_W + DATA_W + 2 * GAP + 1 + ln1 + ln2) : 2;

        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        @(posedge clk);
        if (mapped) push_exp(a, d);
        #1;
        if (keep) begin
            req_addr = na;
            req_data = nd;
        end else begin
            req_valid = 1'b0;
            req_addr  = 16'($urandom);
            req_data  = 8'($urandom);
        end

        stalled_prev = 1'b0;
        prev_mb      = 2'b00;
        done_lat     = -1;
        rdy_lat      = -1;
        ndone        = 0;
        for (int k = 1; k <= 300; k++) begin
            tx_en = !((k >= st1 && k < st1 + ln1) || (k >= st2 && k < st2 + ln2));
            if (k == abort_k) begin
                tx_en = 1'b1;
                rst_n = 1'b0;
                #1;
                chk({tag, "_abort_outs"},
                    {25'd0, req_ready, bus_data_out, bus_data_out_valid, bus_mode, busy, done, err},
                    32'd0);
                chk({tag, "_abort_left"}, exp_q.size(), 32'd4);
                exp_q.delete();
                repeat (2) begin
                    @(negedge clk);
                    chk({tag, "_abort_nodone"}, {31'd0, done}, 32'd0);
                end
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            if (k == 1) begin
                chk({tag, "_busy1"}, {31'd0, busy}, {31'd0, mapped});
                chk({tag, "_ready_drop"}, {31'd0, req_ready}, 32'd0);
            end
            if (stalled_prev) begin
                chk({tag, "_stall_valid"}, {31'd0, bus_data_out_valid}, 32'd0);
                chk({tag, "_stall_hold"}, {30'd0, bus_mode, bus_data_out}, {30'd0, prev_mb});
            end
            if (mapped && k == gapa_k)
                chk({tag, "_gap_a"}, {29'd0, bus_data_out_valid, bus_mode, bus_data_out}, 32'd2);
            if (done) begin
                ndone++;
                if (done_lat < 0) begin
                    done_lat = k;
                    chk({tag, "_done_frame"}, {29'd0, bus_data_out_valid, bus_mode, err},
                        {31'd0, !mapped});
                end
            end
            if (req_ready) begin
                rdy_lat = k;
                break;
            end
            prev_mb      = {bus_mode, bus_data_out};
            stalled_prev = !tx_en;
            @(posedge clk);
            #1;
        end
        tx_en = 1'b1;
        chk({tag, "_done_lat"}, done_lat, exp_done);
        chk({tag, "_ready_lat"}, rdy_lat, exp_rdy);
        chk({tag, "_ndone"}, ndone, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        tx_en     = 1'b1;
        req_addr  = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs",
            {25'd0, req_ready, bus_data_out, bus_data_out_valid, bus_mode, busy, done, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        send("basic", 16'h4123, 8'hA5, 1'b0, 16'h0, 8'h0, 0, 0, 0, 0, 17, 0);
        send("stall", 16'h4123, 8'hA5, 1'b0, 16'h0, 8'h0, 7, 3, 24, 2, 20, 0);
        send("b2b_a", 16'h0400, 8'h3C, 1'b1, 16'h8001, 8'hFF, 0, 0, 0, 0, 17, 0);
        send("b2b_b", 16'h8001, 8'hFF, 1'b0, 16'h0, 8'h0, 0, 0, 0, 0, 17, 0);
        send("abort", 16'h4123, 8'hA5, 1'b0, 16'h0, 8'h0, 0, 0, 0, 0, 17, 22);
        send("after", 16'h4123, 8'hA5, 1'b0, 16'h0, 8'h0, 0, 0, 0, 0, 17, 0);
        send("unmap", 16'hC000, 8'h5A, 1'b0, 16'h0, 8'h0, 0, 0, 0, 0, 17, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("final_idle", {30'd0, req_ready, busy}, 32'd2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
